// File: rtl/flappy_pkg.sv
// +----------------------------------------------------------------------------+
// | flappy_pkg : shared scan states and playfield geometry                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cd_state_e;

    localparam int BIRD_X   = 160;
    localparam int BIRD_W   = 16;
    localparam int BIRD_H   = 16;
    localparam int PIPE_W   = 32;
    localparam int SCREEN_H = 480;

endpackage

`default_nettype wire

// File: rtl/pipe_hit_check.sv
// +----------------------------------------------------------------------------+
// | pipe_hit_check : combinational bird-box vs. one pipe column/gap test       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_hit_check
    import flappy_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic [Y_W-1:0] bird_y,
    input  logic [X_W-1:0] pipe_x,
    input  logic [Y_W-1:0] gap_top,
    input  logic [Y_W-1:0] gap_bot,
    input  logic           pipe_valid,
    output logic           hit
);

    // One extra bit of headroom so edge sums never wrap
    localparam logic [X_W:0] BIRD_L  = (X_W+1)'(BIRD_X);
    localparam logic [X_W:0] BIRD_R  = (X_W+1)'(BIRD_X + BIRD_W);
    localparam logic [X_W:0] PIPE_WX = (X_W+1)'(PIPE_W);
    localparam logic [Y_W:0] BIRD_HB = (Y_W+1)'(BIRD_H - 1);

    logic [X_W:0] px;
    logic [Y_W:0] by;
    logic         x_overlap;
    logic         y_miss;

    assign px        = {1'b0, pipe_x};
    assign by        = {1'b0, bird_y};
    assign x_overlap = (px < BIRD_R) && ((px + PIPE_WX) > BIRD_L);
    assign y_miss    = (by < {1'b0, gap_top}) || ((by + BIRD_HB) > {1'b0, gap_bot});
    assign hit       = pipe_valid && x_overlap && y_miss;

endmodule

`default_nettype wire

// File: rtl/collision_detector.sv
// +----------------------------------------------------------------------------+
// | collision_detector : per-frame pipe-table scan driving a sticky collision  |
// | flag. Optional pass counter enabled by defining SCORE_EN.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module collision_detector
    import flappy_pkg::*;
#(
    parameter  int NUM_PIPES = 4,
    parameter  int X_W       = 10,
    parameter  int Y_W       = 9,
    localparam int IDX_W     = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             restart,
    input  logic [Y_W-1:0]   bird_y,
    output logic [IDX_W-1:0] pipe_idx,
    output logic             pipe_rd,
    input  logic             pipe_valid,
    input  logic [X_W-1:0]   pipe_x,
    input  logic [Y_W-1:0]   gap_top,
    input  logic [Y_W-1:0]   gap_bot,
    output logic             collision,
    output logic             check_done,
    output logic [7:0]       score
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIPES - 1);
    localparam logic [Y_W:0]     BIRD_HY   = (Y_W+1)'(BIRD_H);
    localparam logic [Y_W:0]     SCREEN_HY = (Y_W+1)'(SCREEN_H);

    cd_state_e        state;
    logic [Y_W-1:0]   bird_q;
    logic             data_vld;
    logic [IDX_W-1:0] eval_idx;
    logic             pipe_hit;
    logic             bounds_hit;
    logic             first_scan;
    logic             hit_now;

    pipe_hit_check #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_hit (
        .bird_y     (bird_q),
        .pipe_x     (pipe_x),
        .gap_top    (gap_top),
        .gap_bot    (gap_bot),
        .pipe_valid (pipe_valid),
        .hit        (pipe_hit)
    );

    assign bounds_hit = (bird_q == '0) || (({1'b0, bird_q} + BIRD_HY) > SCREEN_HY);
    assign first_scan = pipe_rd && (pipe_idx == '0);
    assign hit_now    = (state == SCAN) &&
                        ((first_scan && bounds_hit) || (data_vld && pipe_hit));

    // Slot k's data returns the cycle after its read, so eval trails issue by one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bird_q     <= '0;
            pipe_idx   <= '0;
            pipe_rd    <= 1'b0;
            data_vld   <= 1'b0;
            eval_idx   <= '0;
            collision  <= 1'b0;
            check_done <= 1'b0;
        end else if (restart) begin
            state      <= IDLE;
            pipe_idx   <= '0;
            pipe_rd    <= 1'b0;
            data_vld   <= 1'b0;
            eval_idx   <= '0;
            collision  <= 1'b0;
            check_done <= 1'b0;
        end else begin
            check_done <= 1'b0;
            data_vld   <= pipe_rd;
            eval_idx   <= pipe_idx;
            if (hit_now) begin
                collision <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_tick && !collision) begin
                        bird_q   <= bird_y;
                        pipe_idx <= '0;
                        pipe_rd  <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (pipe_rd) begin
                        if (pipe_idx == LAST_IDX) begin
                            pipe_rd <= 1'b0;
                        end else begin
                            pipe_idx <= pipe_idx + IDX_W'(1);
                        end
                    end
                    if (data_vld && (eval_idx == LAST_IDX)) begin
                        check_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_EN
    localparam logic [X_W:0] BIRD_LX = (X_W+1)'(BIRD_X);
    localparam logic [X_W:0] PIPE_WX = (X_W+1)'(PIPE_W);

    logic [NUM_PIPES-1:0] passed;
    logic                 pipe_behind;

    assign pipe_behind = ({1'b0, pipe_x} + PIPE_WX) <= BIRD_LX;

    // A slot counts once; it re-arms when its pipe respawns ahead or empties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            passed <= '0;
            score  <= '0;
        end else if (restart) begin
            passed <= '0;
            score  <= '0;
        end else if ((state == SCAN) && data_vld) begin
            if (!pipe_valid || !pipe_behind) begin
                passed[eval_idx] <= 1'b0;
            end else if (!collision && !passed[eval_idx]) begin
                passed[eval_idx] <= 1'b1;
                if (score != 8'hFF) begin
                    score <= score + 8'd1;
                end
            end
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_collision_detector.sv
// +----------------------------------------------------------------------------+
// | tb_collision_detector : directed + random frames against a reference model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_collision_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       restart;
    logic [8:0] bird_y;
    logic [1:0] pipe_idx;
    logic       pipe_rd;
    logic       pipe_valid;
    logic [9:0] pipe_x;
    logic [8:0] gap_top;
    logic [8:0] gap_bot;
    logic       collision;
    logic       check_done;
    logic [7:0] score;

    int vectors     = 0;
    int miscompares = 0;

    logic t_vld [4];
    int   t_x   [4];
    int   t_gt  [4];
    int   t_gb  [4];

    int m_coll;
    int m_score;
    bit m_passed [4];

    always #5 clk = ~clk;

    collision_detector #(
        .NUM_PIPES (4),
        .X_W       (10),
        .Y_W       (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .restart    (restart),
        .bird_y     (bird_y),
        .pipe_idx   (pipe_idx),
        .pipe_rd    (pipe_rd),
        .pipe_valid (pipe_valid),
        .pipe_x     (pipe_x),
        .gap_top    (gap_top),
        .gap_bot    (gap_bot),
        .collision  (collision),
        .check_done (check_done),
        .score      (score)
    );

    // Pipe table with one-cycle read latency
    always @(posedge clk) begin
        if (pipe_rd) begin
            pipe_valid <= t_vld[pipe_idx];
            pipe_x     <= 10'(t_x[pipe_idx]);
            gap_top    <= 9'(t_gt[pipe_idx]);
            gap_bot    <= 9'(t_gb[pipe_idx]);
        end else begin
            pipe_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame outcome from the geometry rules, slots visited in order
    function automatic void model_frame(input int by);
        bit hit;
        if (m_coll != 0) return;
        if (by == 0 || by + 16 > 480) m_coll = 1;
        for (int k = 0; k < 4; k++) begin
            if (t_vld[k]) begin
                hit = (t_x[k] < 176) && (t_x[k] + 32 > 160) &&
                      ((by < t_gt[k]) || (by + 15 > t_gb[k]));
`ifdef SCORE_EN
                if (t_x[k] + 32 > 160) m_passed[k] = 1'b0;
                else if (m_coll == 0 && !m_passed[k]) begin
                    m_passed[k] = 1'b1;
                    if (m_score < 255) m_score++;
                end
`endif
                if (hit) m_coll = 1;
            end else begin
                m_passed[k] = 1'b0;
            end
        end
    endfunction

    task automatic model_clear();
        m_coll  = 0;
        m_score = 0;
        for (int k = 0; k < 4; k++) m_passed[k] = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic v, input int x, input int gt, input int gb);
        t_vld[k] = v;
        t_x[k]   = x;
        t_gt[k]  = gt;
        t_gb[k]  = gb;
    endtask

    task automatic do_frame(input int by, input string tag);
        int pre;
        int cyc;
        bit seen;
        pre = m_coll;
        model_frame(by);
        @(negedge clk);
        bird_y     = 9'(by);
        frame_tick = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) frame_tick = 1'b0;
            if (check_done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        if (pre != 0) check({tag, ".nodone"}, 32'(seen), 32'd0);
        else          check({tag, ".latency"}, 32'(cyc), 32'd6);
        check({tag, ".collision"}, 32'(collision), 32'(m_coll));
        check({tag, ".score"}, 32'(score), 32'(m_score));
        @(negedge clk);
    endtask

    task automatic restart_pulse(input string tag);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_clear();
        check({tag, ".collision"}, 32'(collision), 32'd0);
        check({tag, ".score"}, 32'(score), 32'd0);
        check({tag, ".pipe_rd"}, 32'(pipe_rd), 32'd0);
    endtask

    initial begin
        bit stray;
        int by;
        reset      = 1'b0;
        frame_tick = 1'b0;
        restart    = 1'b0;
        bird_y     = '0;
        for (int k = 0; k < 4; k++) set_slot(k, 1'b0, 0, 0, 0);
        model_clear();

        repeat (3) @(negedge clk);
        check("rst.collision", 32'(collision), 32'd0);
        check("rst.check_done", 32'(check_done), 32'd0);
        check("rst.pipe_rd", 32'(pipe_rd), 32'd0);
        check("rst.pipe_idx", 32'(pipe_idx), 32'd0);
        check("rst.score", 32'(score), 32'd0);
        reset = 1'b1;

        // Reset dropped mid-scan after a ceiling hit
        @(negedge clk);
        bird_y     = 9'd0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("t1.pipe_rd", 32'(pipe_rd), 32'd1);
        check("t1.pipe_idx", 32'(pipe_idx), 32'd0);
        @(negedge clk);
        check("t1.ceiling_hit", 32'(collision), 32'd1);
        reset = 1'b0;
        #1;
        check("t1.async_collision", 32'(collision), 32'd0);
        check("t1.async_check_done", 32'(check_done), 32'd0);
        check("t1.async_pipe_rd", 32'(pipe_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();

        // Clear path through four distant pipes
        for (int k = 0; k < 4; k++) set_slot(k, 1'b1, 400 + 200 * k, 150, 300);
        do_frame(200, "t2");

        // Pipe column hit, then sticky across ignored ticks
        set_slot(0, 1'b1, 150, 150, 300);
        do_frame(100, "t3");
        for (int i = 0; i < 3; i++) do_frame(200, "t3.hold");
        restart_pulse("t3.restart");

        // Floor and ceiling with empty table
        for (int k = 0; k < 4; k++) set_slot(k, 1'b0, 0, 0, 0);
        do_frame(470, "t4.floor");
        restart_pulse("t4.restart_a");
        do_frame(0, "t4.ceiling");
        restart_pulse("t4.restart_b");

        // Restart coincides with slot 0's hitting evaluation
        set_slot(0, 1'b1, 150, 150, 300);
        @(negedge clk);
        bird_y     = 9'd100;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5.collision", 32'(collision), 32'd0);
        check("t5.pipe_rd", 32'(pipe_rd), 32'd0);
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (check_done) stray = 1'b1;
        end
        check("t5.no_done", 32'(stray), 32'd0);
        set_slot(0, 1'b0, 0, 0, 0);
        do_frame(200, "t5.clear");

        // Pipe drifting past the bird, then respawning
        set_slot(0, 1'b1, 140, 150, 300);
        do_frame(200, "t6.x140");
        t_x[0] = 120; do_frame(200, "t6.x120");
        t_x[0] = 100; do_frame(200, "t6.x100");
        t_x[0] = 600; do_frame(200, "t6.x600");
        t_x[0] = 120; do_frame(200, "t6.x120b");
`ifdef SCORE_EN
        check("t6.score_two", 32'(score), 32'd2);
`else
        check("t6.score_tied", 32'(score), 32'd0);
`endif

        // Random frames
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) begin
                t_vld[k] = 1'($urandom % 2);
                t_x[k]   = ($urandom % 2 == 0) ? int'($urandom_range(100, 250))
                                               : int'($urandom_range(0, 1023));
                t_gt[k]  = int'($urandom_range(0, 400));
                t_gb[k]  = t_gt[k] + int'($urandom_range(0, 479 - t_gt[k]));
            end
            by = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 479));
            do_frame(by, "rnd");
            if (m_coll != 0 && ($urandom % 2) == 0) restart_pulse("rnd.restart");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
